md_unit: RTL and testbench

- Multiply/divide unit in the E stage of the five-stage MIPS pipeline.
- Consumes the forwarded RS_E/RT_E operands and owns the HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO for MFHI/MFLO, and a busy flag the conflict unit uses to stall any multiply/divide-class instruction in D while an operation is in flight.

---
 rtl/md_unit.sv | 150 +++++++++++++++
 tb/tb_md_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning the HI/LO registers.
// Latency: MULT/MULTU take MULT_CYCLES and DIV/DIVU take DIV_CYCLES of busy; MTHI/MTLO write HI/LO on the accepting edge.
// Backpressure: busy stays high while an op is in flight; a start seen then is dropped, except on the completion edge.
// Ports: clk, reset (async active-low), start/md_op (op request), a/b (rs/rt operands),
//        busy (op in flight), hi/lo (registered HI/LO).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  // Arithmetic on the operands present at the accepting edge.
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] div_a_s, div_b_s;
  logic [31:0]        q_s, r_s, q_u, r_u, div_b_u;
  logic               b_zero, b_neg1;

  always_comb begin
    b_zero  = (b == 32'd0);
    b_neg1  = (b == 32'hFFFF_FFFF);
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u  = {32'd0, a} * {32'd0, b};
    // Divisors forced to 1 where the real answer is produced another way,
    // so the dividers never see a zero or the INT_MIN / -1 overflow case.
    div_a_s = $signed(a);
    div_b_s = (b_zero || b_neg1) ? 32'sd1 : $signed(b);
    div_b_u = b_zero ? 32'd1 : b;
    // Division by -1 is negation; this also yields 0x80000000 for INT_MIN.
    q_s     = b_neg1 ? (32'd0 - a) : $unsigned(div_a_s / div_b_s);
    r_s     = b_neg1 ? 32'd0       : $unsigned(div_a_s % div_b_s);
    q_u     = a / div_b_u;
    r_u     = a % div_b_u;
  end

  // The completion edge can also accept the next op (back-to-back issue).
  logic finish, accept;
  assign finish = (state_q == RUN) && (cnt_q == 4'd1);
  assign accept = start && ((state_q == IDLE) || finish);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (state_q == RUN) begin
      if (finish) begin
        // Divide by zero leaves HI/LO untouched.
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end

    // Evaluated after the commit so MTHI/MTLO override the committed half.
    if (accept) begin
      case (md_op)
        OP_MULT: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_N;
          state_d   = RUN;
        end
        OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_N;
          state_d   = RUN;
        end
        OP_DIV: begin
          pend_hi_d = r_s;
          pend_lo_d = q_s;
          pend_wr_d = !b_zero;
          cnt_d     = DIV_N;
          state_d   = RUN;
        end
        OP_DIVU: begin
          pend_hi_d = r_u;
          pend_lo_d = q_u;
          pend_wr_d = !b_zero;
          cnt_d     = DIV_N;
          state_d   = RUN;
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
// Each scenario task checks its own results against hand-computed values.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Present one op across a single rising edge; returns 1 ns after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'd0;
  endtask

  // Counts sampled busy cycles until busy drops (bounded at 40).
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    @(posedge clk); #1;
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL mult_hold: got %h_%h expected 00000000_00000000", hi, lo); end
    count_busy(n);
    n = n + 1;
    n_cmp++; if (n != 5) begin n_err++; $display("FAIL mult_busy: got %0d expected 5", n); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
  endtask

  task automatic test_multu;
    int n;
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    n_cmp++; if (n != 5) begin n_err++; $display("FAIL multu_busy: got %0d expected 5", n); end
    n_cmp++; if (hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
  endtask

  task automatic test_div;
    int n;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL div_busy: got %0d expected 10", n); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
  endtask

  task automatic test_div_overflow;
    int n;
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_div_zero;
    int n;
    issue(3'd5, 32'h1234_5678, 32'd0);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
    issue(3'd6, 32'h9ABC_DEF0, 32'd0);
    n_cmp++; if (lo !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL mtlo_lo: got %h expected 9abcdef0", lo); end
    issue(3'd4, 32'd77, 32'd0);
    count_busy(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL divz_busy: got %0d expected 10", n); end
    n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL divz_hi: got %h expected 12345678", hi); end
    n_cmp++; if (lo !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL divz_lo: got %h expected 9abcdef0", lo); end
  endtask

  // MULT 3*4 accepted at t0; MTLO presented on the completion edge t0+5.
  task automatic test_back_to_back;
    issue(3'd1, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_last: got %b expected 1", busy); end
    start = 1'b1;
    md_op = 3'd6;
    a     = 32'h55;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'd0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL b2b_hi: got %h expected 00000000", hi); end
    n_cmp++; if (lo !== 32'h55) begin n_err++; $display("FAIL b2b_lo: got %h expected 00000055", lo); end
  endtask

  // MTHI and DIV pulsed mid-run must not alter the MULT result or its timing.
  task automatic test_start_in_run;
    int n;
    issue(3'd1, 32'd5, 32'd6);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      if (i == 1 || i == 2) begin
        @(negedge clk);
        start = 1'b1;
        md_op = (i == 1) ? 3'd5 : 3'd3;
        a     = 32'hDEAD_BEEF;
        b     = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = 3'd0;
    end
    n_cmp++; if (n != 5) begin n_err++; $display("FAIL sir_busy: got %0d expected 5", n); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL sir_hi: got %h expected 00000000", hi); end
    n_cmp++; if (lo !== 32'd30) begin n_err++; $display("FAIL sir_lo: got %h expected 0000001e", lo); end
  endtask

  task automatic test_reset_mid_run;
    issue(3'd5, 32'hCAFE_0001, 32'd0);
    issue(3'd4, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_run_busy: got %b expected 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL rst_run_hi: got %h expected 00000000", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL rst_run_lo: got %h expected 00000000", lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL rst_run_discard: got %h_%h expected 00000000_00000000", hi, lo); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_overflow;
    test_div_zero;
    test_back_to_back;
    test_start_in_run;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
